// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle MIPS core: fetch/decode/execute/memory/write-back.
// Optional retired-instruction counter built only when PERF_COUNTER_EN is defined.
module multicycle_control_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        flag_R_type,
   input  logic        flag_I_type,
   input  logic        flag_lw,
   input  logic        flag_sw,
   input  logic        destination_indicator,
   input  logic [3:0]  ALUControl_in,
   input  logic [1:0]  mux4selector,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        IorD,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        PCWrite,
   output logic        RegDst,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [3:0]  ALUControl,
   output logic [1:0]  PCSrc,
   output logic [3:0]  state,
   output logic        instr_done,
   output logic        illegal_op,
   output logic [31:0] retired_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_ALUWB  = 4'd7,
      S_EXEC_I = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10
   } state_t;

   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [3:0] ALU_ADD = 4'd2;

   state_t cur;
   state_t dec_next;
   logic   dec_illegal;

   // The decoder's type flag is informational here; opcodes select EXEC_I directly.
   logic unused_inputs;
   assign unused_inputs = flag_I_type;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      dec_next    = S_FETCH;
      dec_illegal = 1'b0;
      if (flag_R_type)
         dec_next = S_EXEC_R;
      else if (flag_lw || flag_sw)
         dec_next = S_MEMADR;
      else if (opcode == OP_ADDI || opcode == OP_ANDI)
         dec_next = S_EXEC_I;
      else if (opcode == OP_BEQ || opcode == OP_BNE)
         dec_next = S_BRANCH;
      else if (opcode == OP_J)
         dec_next = S_JUMP;
      else
         dec_illegal = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= S_FETCH;
      end else begin
         case (cur)
            S_FETCH:            if (mem_ready) cur <= S_DECODE;
            S_DECODE:           cur <= dec_next;
            S_MEMADR:           cur <= flag_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:            if (mem_ready) cur <= S_MEMWB;
            S_MEMWR:            if (mem_ready) cur <= S_FETCH;
            S_EXEC_R, S_EXEC_I: cur <= S_ALUWB;
            default:            cur <= S_FETCH;
         endcase
      end
   end

   assign state = cur;

   always_comb begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      PCWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'd0;
      ALUControl = 4'd0;
      PCSrc      = 2'd0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (cur)
         S_FETCH: begin
            ALUSrcB    = 2'd1;
            ALUControl = ALU_ADD;
            IRWrite    = mem_ready;
            PCWrite    = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB    = 2'd3;
            ALUControl = ALU_ADD;
            illegal_op = dec_illegal;
            instr_done = dec_illegal;
         end
         S_EXEC_R, S_EXEC_I: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = mux4selector;
            ALUControl = ALUControl_in;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = destination_indicator;
            instr_done = 1'b1;
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'd2;
            ALUControl = ALU_ADD;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALUControl_in;
            PCSrc      = 2'd1;
            instr_done = 1'b1;
            PCWrite    = (opcode == OP_BEQ) ? zero : (opcode == OP_BNE) ? ~zero : 1'b0;
         end
         S_JUMP: begin
            PCSrc      = 2'd2;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // Reset aborts the instruction in flight: nothing may commit on the reset edge.
      if (reset) begin
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         PCWrite    = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

`ifdef PERF_COUNTER_EN
   logic [31:0] count_q;

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= 32'd0;
      else if (instr_done)
         count_q <= count_q + 32'd1;
   end

   assign retired_count = count_q;
`else
   assign retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios plus a random
// instruction stream checked cycle by cycle against a per-instruction cycle-list model.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        flag_R_type, flag_I_type, flag_lw, flag_sw;
   logic        destination_indicator;
   logic [3:0]  ALUControl_in;
   logic [1:0]  mux4selector;
   logic        zero;
   logic        mem_ready;
   logic        IorD, MemWrite, IRWrite, RegWrite, PCWrite, RegDst, MemtoReg, ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [3:0]  ALUControl;
   logic [1:0]  PCSrc;
   logic [3:0]  state;
   logic        instr_done, illegal_op;
   logic [31:0] retired_count;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .flag_R_type(flag_R_type), .flag_I_type(flag_I_type), .flag_lw(flag_lw), .flag_sw(flag_sw),
      .destination_indicator(destination_indicator), .ALUControl_in(ALUControl_in),
      .mux4selector(mux4selector), .zero(zero), .mem_ready(mem_ready),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .PCSrc(PCSrc), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   typedef enum {K_ADD, K_ADDI, K_ANDI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL} kind_t;

   typedef struct packed {
      logic [3:0] st;
      logic       iord, memw, irw, regw, pcw, regdst, memtoreg, srca;
      logic [1:0] srcb;
      logic [3:0] aluc;
      logic [1:0] pcsrc;
      logic       done, ill;
   } exp_t;

   typedef struct {
      exp_t e;
      logic mr;
   } cyc_t;

   cyc_t q[$];
   int   total = 0;
   int   bad = 0;
   int   exp_retired = 0;

   function automatic logic [31:0] exp_ret();
`ifdef PERF_COUNTER_EN
      return 32'(exp_retired);
`else
      return 32'd0;
`endif
   endfunction

   function automatic exp_t at_state(input logic [3:0] st);
      exp_t e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.st = state; o.iord = IorD; o.memw = MemWrite; o.irw = IRWrite; o.regw = RegWrite;
      o.pcw = PCWrite; o.regdst = RegDst; o.memtoreg = MemtoReg; o.srca = ALUSrcA;
      o.srcb = ALUSrcB; o.aluc = ALUControl; o.pcsrc = PCSrc; o.done = instr_done;
      o.ill = illegal_op;
      return o;
   endfunction

   task automatic push(input exp_t e, input logic mr);
      cyc_t c;
      c.e = e;
      c.mr = mr;
      q.push_back(c);
   endtask

   // Plays the decoder: holds the instruction's flags and pass-through fields.
   task automatic set_instr(input kind_t k, input logic [5:0] ill_op, input logic z);
      flag_R_type = 0; flag_I_type = 0; flag_lw = 0; flag_sw = 0;
      ALUControl_in = 4'($urandom_range(0, 15));
      mux4selector = 2'($urandom_range(0, 3));
      destination_indicator = 1'($urandom_range(0, 1));
      zero = z;
      case (k)
         K_ADD:  begin opcode = 6'h00; flag_R_type = 1; end
         K_ADDI: begin opcode = 6'h08; flag_I_type = 1; end
         K_ANDI: begin opcode = 6'h0C; flag_I_type = 1; end
         K_LW:   begin opcode = 6'h23; flag_I_type = 1; flag_lw = 1; end
         K_SW:   begin opcode = 6'h2B; flag_I_type = 1; flag_sw = 1; end
         K_BEQ:  opcode = 6'h04;
         K_BNE:  opcode = 6'h05;
         K_J:    opcode = 6'h02;
         default: begin opcode = ill_op; flag_I_type = 1'($urandom_range(0, 1)); end
      endcase
   endtask

   // Expected cycle list for one instruction: fw fetch waits, mw memory waits.
   task automatic build(input kind_t k, input int fw, input int mw);
      exp_t e;
      for (int i = 0; i <= fw; i++) begin
         e = at_state(4'd0); e.srcb = 2'd1; e.aluc = 4'd2;
         e.irw = (i == fw); e.pcw = (i == fw);
         push(e, i == fw);
      end
      e = at_state(4'd1); e.srcb = 2'd3; e.aluc = 4'd2;
      if (k == K_ILL) begin e.done = 1; e.ill = 1; end
      push(e, 1'($urandom_range(0, 1)));
      case (k)
         K_ADD, K_ADDI, K_ANDI: begin
            e = at_state(k == K_ADD ? 4'd6 : 4'd8);
            e.srca = 1; e.srcb = mux4selector; e.aluc = ALUControl_in;
            push(e, 1'($urandom_range(0, 1)));
            e = at_state(4'd7); e.regw = 1; e.regdst = destination_indicator; e.done = 1;
            push(e, 1'($urandom_range(0, 1)));
         end
         K_LW, K_SW: begin
            e = at_state(4'd2); e.srca = 1; e.srcb = 2'd2; e.aluc = 4'd2;
            push(e, 1'($urandom_range(0, 1)));
            for (int i = 0; i <= mw; i++) begin
               if (k == K_LW) begin
                  e = at_state(4'd3); e.iord = 1;
               end else begin
                  e = at_state(4'd5); e.iord = 1; e.memw = 1; e.done = (i == mw);
               end
               push(e, i == mw);
            end
            if (k == K_LW) begin
               e = at_state(4'd4); e.regw = 1; e.memtoreg = 1; e.done = 1;
               push(e, 1'($urandom_range(0, 1)));
            end
         end
         K_BEQ, K_BNE: begin
            e = at_state(4'd9); e.srca = 1; e.aluc = ALUControl_in; e.pcsrc = 2'd1; e.done = 1;
            e.pcw = (k == K_BEQ) ? zero : ~zero;
            push(e, 1'($urandom_range(0, 1)));
         end
         K_J: begin
            e = at_state(4'd10); e.pcsrc = 2'd2; e.pcw = 1; e.done = 1;
            push(e, 1'($urandom_range(0, 1)));
         end
         default: ;
      endcase
   endtask

   // Entered and left at posedge+1.
   task automatic run_queue(input string tag, input int limit);
      int n = 0;
      while (q.size() > 0 && n < limit) begin
         cyc_t c;
         exp_t o;
         c = q.pop_front();
         mem_ready = c.mr;
         #1;
         o = observed();
         total++;
         if (o !== c.e) begin
            bad++;
            $display("FAIL %s cycle %0d outputs: got %b want %b", tag, n, o, c.e);
         end
         total++;
         if (retired_count !== exp_ret()) begin
            bad++;
            $display("FAIL %s cycle %0d retired_count: got %0d want %0d", tag, n, retired_count, exp_ret());
         end
         if (c.e.done) exp_retired++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_reset();
      reset = 1; mem_ready = 0;
      @(posedge clk); #1;
      reset = 0;
      exp_retired = 0;
      q.delete();
   endtask

   task automatic test_reset();
      exp_t want;
      set_instr(K_ADD, 6'h00, 1'b0);
      reset = 1; mem_ready = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (state !== 4'd0) begin
         bad++; $display("FAIL reset_state: got %0d want 0", state);
      end
      total++;
      if (retired_count !== 32'd0) begin
         bad++; $display("FAIL reset_count: got %0d want 0", retired_count);
      end
      total++;
      if ({IRWrite, PCWrite, MemWrite, RegWrite, instr_done, illegal_op} !== 6'b0) begin
         bad++;
         $display("FAIL reset_strobes: got %b want 000000",
                  {IRWrite, PCWrite, MemWrite, RegWrite, instr_done, illegal_op});
      end
      reset = 0; mem_ready = 0;
      #1;
      want = at_state(4'd0); want.srcb = 2'd1; want.aluc = 4'd2;
      total++;
      if (observed() !== want) begin
         bad++; $display("FAIL post_reset outputs: got %b want %b", observed(), want);
      end
      exp_retired = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      set_instr(K_ADD, 6'h00, 1'b0);
      destination_indicator = 1;
      build(K_ADD, 0, 0);
      run_queue("add", 100);
   endtask

   task automatic test_lw_wait();
      set_instr(K_LW, 6'h00, 1'b0);
      build(K_LW, 0, 2);
      run_queue("lw_wait", 100);
   endtask

   task automatic test_sw_wait();
      set_instr(K_SW, 6'h00, 1'b0);
      build(K_SW, 1, 3);
      run_queue("sw_wait", 100);
   endtask

   task automatic test_branch();
      for (int i = 0; i < 4; i++) begin
         set_instr((i % 2 == 0) ? K_BEQ : K_BNE, 6'h00, (i < 2));
         build((i % 2 == 0) ? K_BEQ : K_BNE, 0, 0);
         run_queue("branch", 100);
      end
   endtask

   task automatic test_jump();
      set_instr(K_J, 6'h00, 1'b0);
      build(K_J, 0, 0);
      run_queue("jump", 100);
   endtask

   task automatic test_illegal();
      do_reset();
      set_instr(K_ILL, 6'h3F, 1'b0);
      build(K_ILL, 0, 0);
      run_queue("illegal", 100);
      total++;
      if (retired_count !== exp_ret()) begin
         bad++; $display("FAIL illegal_retired: got %0d want %0d", retired_count, exp_ret());
      end
   endtask

   task automatic test_reset_mid_sw();
      set_instr(K_SW, 6'h00, 1'b0);
      build(K_SW, 0, 5);
      run_queue("sw_abort", 4);
      q.delete();
      mem_ready = 0;
      #1;
      total++;
      if (MemWrite !== 1'b1 || state !== 4'd5) begin
         bad++; $display("FAIL abort_pre: got MemWrite=%b state=%0d want 1/5", MemWrite, state);
      end
      reset = 1;
      #1;
      total++;
      if ({MemWrite, RegWrite, instr_done} !== 3'b000) begin
         bad++; $display("FAIL abort_drop: got %b want 000", {MemWrite, RegWrite, instr_done});
      end
      @(posedge clk); #1;
      total++;
      if (state !== 4'd0 || retired_count !== 32'd0) begin
         bad++; $display("FAIL abort_after: got state=%0d count=%0d want 0/0", state, retired_count);
      end
      reset = 0;
      exp_retired = 0;
   endtask

   task automatic test_random_stream();
      logic [5:0] ill_ops [4];
      ill_ops[0] = 6'h3F; ill_ops[1] = 6'h0A; ill_ops[2] = 6'h01; ill_ops[3] = 6'h20;
      for (int i = 0; i < 80; i++) begin
         kind_t k;
         k = kind_t'($urandom_range(0, 8));
         set_instr(k, ill_ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
         build(k, $urandom_range(0, 3), $urandom_range(0, 3));
         run_queue("random", 100);
      end
   endtask

   initial begin
      reset = 1; mem_ready = 0; zero = 0; opcode = 0;
      flag_R_type = 0; flag_I_type = 0; flag_lw = 0; flag_sw = 0;
      destination_indicator = 0; ALUControl_in = 0; mux4selector = 0;
      test_reset();
      test_add();
      test_lw_wait();
      test_sw_wait();
      test_branch();
      test_jump();
      test_illegal();
      test_reset_mid_sw();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main sequencer of the multicycle MIPS core; sits directly downstream of the instruction decoder. Consumes the decoder's type flags, ALU operation code and srcB selection, plus the raw opcode, and steps each instruction through fetch / decode / execute / memory / write-back. It drives every datapath enable and mux select, and handshakes with the shared instruction/data memory through `mem_ready`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26], registered instruction
- `flag_R_type`, `flag_I_type`, `flag_lw`, `flag_sw`  in  1 each  decoder flags
- `destination_indicator`  in  1  decoder: 1 = rd, 0 = rt
- `ALUControl_in`  in  4  decoder ALU code
- `mux4selector`  in  2  decoder srcB select
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemWrite`, `IRWrite`, `RegWrite`, `PCWrite`  out  1 each  write strobes
- `RegDst`  out  1  register-file write address: 1 = rd, 0 = rt
- `MemtoReg`  out  1  register write data: 1 = memory data, 0 = ALUOut
- `ALUSrcA`  out  1  0 = PC, 1 = regA
- `ALUSrcB`  out  2  0 = regB, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- `ALUControl`  out  4  ALU operation
- `PCSrc`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- `state`  out  4  current state, for debug
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode
- `retired_count`  out  32  retired-instruction counter (see Configuration)

## Operation
- State encoding, 4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB=7, EXEC_I=8, BRANCH=9, JUMP=10.
- Outputs are decoded combinationally from `state` and the inputs (Moore plus `mem_ready`/`zero` gating). Any output not listed for a state is 0.
- **FETCH**
  - Drives `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1, `ALUControl`=2, `PCSrc`=0.
  - `IRWrite` and `PCWrite` = `mem_ready`.
  - Goes to DECODE when `mem_ready`=1; otherwise stays in FETCH.
- **DECODE**
  - Drives `ALUSrcA`=0, `ALUSrcB`=3, `ALUControl`=2 (branch target into ALUOut).
  - Next state by opcode:
    - `flag_R_type` → EXEC_R.
    - `flag_lw` or `flag_sw` → MEMADR.
    - 0x08 or 0x0C → EXEC_I.
    - 0x04 or 0x05 → BRANCH.
    - 0x02 → JUMP.
    - Anything else: pulse `illegal_op` and `instr_done`, go to FETCH. The instruction counts as retired.
- **EXEC_R**: `ALUSrcA`=1, `ALUSrcB`=`mux4selector`, `ALUControl`=`ALUControl_in`; → ALUWB.
- **EXEC_I**: same as EXEC_R; → ALUWB.
- **ALUWB**: `RegWrite`=1, `RegDst`=`destination_indicator`, `MemtoReg`=0, `instr_done`=1; → FETCH.
- **MEMADR**
  - Drives `ALUSrcA`=1, `ALUSrcB`=2 (overrides the decoder), `ALUControl`=2 (forced add).
  - → MEMRD if `flag_lw`, else MEMWR.
- **MEMRD**: `IorD`=1; → MEMWB when `mem_ready`=1, else stays.
- **MEMWB**: `RegWrite`=1, `RegDst`=0, `MemtoReg`=1, `instr_done`=1; → FETCH.
- **MEMWR**
  - Drives `IorD`=1, `MemWrite`=1, held until `mem_ready`=1.
  - `instr_done`=`mem_ready`; → FETCH when `mem_ready`=1.
- **BRANCH**
  - Drives `ALUSrcA`=1, `ALUSrcB`=0, `ALUControl`=`ALUControl_in`, `PCSrc`=1, `instr_done`=1; → FETCH.
  - `PCWrite` = `zero` for beq (0x04), `!zero` for bne (0x05).
- **JUMP**: `PCSrc`=2, `PCWrite`=1, `instr_done`=1; → FETCH.
- Illegal `state` values (11–15) → FETCH on the next edge; all outputs 0 while in them.

## Timing
- `reset` sampled on the `clk` rising edge:
  - `state` ← FETCH.
  - `retired_count` ← 0.
  - While `reset`=1, all write strobes, `instr_done` and `illegal_op` are forced to 0.
- Post-reset values with `mem_ready`=0:
  - `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1, `ALUControl`=2, `PCSrc`=0.
  - `RegDst`=0, `MemtoReg`=0, `state`=0, all strobes 0.
- Reset mid-instruction aborts it: no register or memory write occurs on the reset edge or after it.
- Cycles per instruction with `mem_ready` always 1: R-type 4, addi/andi 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Each memory wait cycle adds one cycle in FETCH, MEMRD or MEMWR. Outputs are held stable while waiting.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.

## Configuration
- `PERF_COUNTER_EN` defined:
  - `retired_count` is a 32-bit register that increments on each cycle with `instr_done`=1.
  - Wraps from 0xFFFFFFFF to 0.
- `PERF_COUNTER_EN` not defined: `retired_count` is tied to 0 and no counter flops are built.

## Test plan
- **add, opcode 0x00, funct 0x20, `mem_ready`=1:** states 0,1,6,7,0. `RegWrite`=1 and `RegDst`=1 only in ALUWB. `instr_done` pulses on cycle 4.
- **lw (0x23) with `mem_ready` low for 2 cycles in MEMRD:** 7 cycles total. MEMADR drives `ALUSrcB`=2, `ALUControl`=2. MEMWB drives `MemtoReg`=1, `RegWrite`=1.
- **sw (0x2B), `mem_ready`=0 for 3 cycles in MEMWR:** `MemWrite` held high 4 cycles. `instr_done` asserts only with `mem_ready`. `RegWrite` never 1.
- **beq with `zero`=1 → `PCWrite`=1, `PCSrc`=1. bne with `zero`=1 → `PCWrite`=0.** Both take 3 cycles.
- **Opcode 0x3F:** `illegal_op` pulses in DECODE, then FETCH. With the macro defined, `retired_count` goes 0 → 1.
- **`reset` asserted in MEMWR with `MemWrite` high:** `MemWrite` drops the same cycle; next cycle `state`=0, `retired_count`=0.
